// File: rtl/hex_pkg.sv
// Shared types and constants for the six-digit hex display controller.
package hex_pkg;

    localparam int HEX_NUM_DIGITS   = 6;
    localparam int HEX_NUM_SEGMENTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } hex_ctrl_state_t;

    localparam logic [HEX_NUM_SEGMENTS-1:0] SEG_BLANK = '1;

    typedef logic [$clog2(HEX_NUM_DIGITS)-1:0] digit_idx_t;

endpackage

// File: rtl/hex_display.sv
// Combinational hex-to-seven-segment decoder, active-low segments, DP at the MSB.
module hex_display #(
    parameter int NUM_SEGMENTS    = 8,
    parameter int BITS_PER_NIBBLE = 4
) (
    input  logic [BITS_PER_NIBBLE-1:0] hex_char,
    input  logic                       enable_dp,
    output logic [NUM_SEGMENTS-1:0]    segments
);

    // enable_dp is active-low and passes straight through to the DP segment
    always_comb begin
        segments                 = '1;
        segments[NUM_SEGMENTS-1] = enable_dp;
        case (hex_char)
            4'h0:    segments[6:0] = 7'h40;
            4'h1:    segments[6:0] = 7'h79;
            4'h2:    segments[6:0] = 7'h24;
            4'h3:    segments[6:0] = 7'h30;
            4'h4:    segments[6:0] = 7'h19;
            4'h5:    segments[6:0] = 7'h12;
            4'h6:    segments[6:0] = 7'h02;
            4'h7:    segments[6:0] = 7'h78;
            4'h8:    segments[6:0] = 7'h00;
            4'h9:    segments[6:0] = 7'h10;
            4'hA:    segments[6:0] = 7'h08;
            4'hB:    segments[6:0] = 7'h03;
            4'hC:    segments[6:0] = 7'h46;
            4'hD:    segments[6:0] = 7'h21;
            4'hE:    segments[6:0] = 7'h06;
            default: segments[6:0] = 7'h0E;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Time-multiplexed six-digit display controller with atomic commit, LZ blanking and DPs.
// Optional blinking is built when HEX_DISPLAY_CTRL_BLINK_EN is defined.
module hex_display_ctrl
    import hex_pkg::*;
#(
    parameter int NUM_DIGITS      = HEX_NUM_DIGITS,
    parameter int NUM_SEGMENTS    = HEX_NUM_SEGMENTS,
    parameter int BITS_PER_NIBBLE = 4,
    parameter int BLINK_DIV       = 25_000_000
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic [NUM_DIGITS*BITS_PER_NIBBLE-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]                dp_in,
    input  logic                                 blank_lz,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [NUM_DIGITS-1:0]                blink_en,
    output logic                                 busy,
    output logic [NUM_DIGITS*NUM_SEGMENTS-1:0]   HEX_OUT
);

    localparam int VALUE_W = NUM_DIGITS * BITS_PER_NIBBLE;
    localparam int BANK_W  = NUM_DIGITS * NUM_SEGMENTS;

    hex_ctrl_state_t state, next_state;

    logic [VALUE_W-1:0]         value_lat;
    logic [NUM_DIGITS-1:0]      dp_lat;
    logic                       lz;
    digit_idx_t                 idx;
    logic [BANK_W-1:0]          shadow;
    logic [BANK_W-1:0]          disp;

    logic [BITS_PER_NIBBLE-1:0] nibble;
    logic [NUM_SEGMENTS-1:0]    dec_seg;
    logic [NUM_SEGMENTS-1:0]    scan_seg;
    logic                       blank_digit;

    assign nibble      = value_lat[idx*BITS_PER_NIBBLE +: BITS_PER_NIBBLE];
    assign blank_digit = lz && (nibble == '0) && (idx != '0);
    assign scan_seg    = blank_digit ? {dec_seg[NUM_SEGMENTS-1], SEG_BLANK[NUM_SEGMENTS-2:0]}
                                     : dec_seg;

    hex_display #(
        .NUM_SEGMENTS    (NUM_SEGMENTS),
        .BITS_PER_NIBBLE (BITS_PER_NIBBLE)
    ) u_decoder (
        .hex_char  (nibble),
        .enable_dp (~dp_lat[idx]),
        .segments  (dec_seg)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_valid) next_state = SCAN;
            SCAN:    if (idx == '0)  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign load_ready = (state == IDLE);
    assign busy       = !load_ready;

    // Scan walks from the most significant digit so the LZ flag sees leading digits first
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value_lat <= '0;
            dp_lat    <= '0;
            lz        <= 1'b0;
            idx       <= digit_idx_t'(NUM_DIGITS-1);
            shadow    <= '1;
            disp      <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        value_lat <= value_in;
                        dp_lat    <= dp_in;
                        lz        <= blank_lz;
                        idx       <= digit_idx_t'(NUM_DIGITS-1);
                    end
                end
                SCAN: begin
                    shadow[idx*NUM_SEGMENTS +: NUM_SEGMENTS] <= scan_seg;
                    if (nibble != '0) lz <= 1'b0;
                    if (idx != '0) idx <= idx - 1'b1;
                end
                COMMIT: disp <= shadow;
                default: ;
            endcase
        end
    end

`ifdef HEX_DISPLAY_CTRL_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV-1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        HEX_OUT = disp;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blink_phase && blink_en[i])
                HEX_OUT[i*NUM_SEGMENTS +: NUM_SEGMENTS] = SEG_BLANK[NUM_SEGMENTS-1:0];
        end
    end
`else
    logic unused_blink;

    assign unused_blink = (^blink_en) ^ (BLINK_DIV < 2);
    assign HEX_OUT      = disp;
`endif

endmodule
